// File: rtl/load_use_stall.sv
// Decode-stage load-use hazard controller: freezes IF/ID and bubbles ID/EX for LOAD_LAT cycles
// when the execute instruction is a load feeding decode; otherwise registers the rs/rt forward selects.
module load_use_stall #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             ex_valid,
    input  logic [15:0]      ex_inst,
    input  logic             forward,
    input  logic             src,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             fwd_rs_q,
    output logic             fwd_rt_q,
    output logic [CNT_W-1:0] stall_events
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [4:0] OP_LOAD  = 5'b10001;
    // The hazard cycle itself is the first bubble, so STALL covers the remaining LOAD_LAT-1.
    localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             fwd_rs_d, fwd_rt_d;
    logic [CNT_W-1:0] events_q, events_d;
    logic             hazard;
    logic             stall_raw, bubble_raw;
    logic             unused_inst;

    assign unused_inst = ^ex_inst[10:0];
    assign hazard      = id_valid & ex_valid & forward & (ex_inst[15:11] == OP_LOAD);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_raw  = 1'b0;
        bubble_raw = 1'b0;
        if (flush) begin
            state_d = RUN;
            cnt_d   = 2'd0;
        end else if (mem_busy) begin
            stall_raw = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        stall_raw  = 1'b1;
                        bubble_raw = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                STALL: begin
                    stall_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        fwd_rs_d = fwd_rs_q;
        fwd_rt_d = fwd_rt_q;
        events_d = events_q;
        if (flush) begin
            fwd_rs_d = 1'b0;
            fwd_rt_d = 1'b0;
        end else if (!mem_busy) begin
            if (bubble_raw) begin
                fwd_rs_d = 1'b0;
                fwd_rt_d = 1'b0;
            end else begin
                fwd_rs_d = id_valid & forward & ~src;
                fwd_rt_d = id_valid & forward & src;
            end
        end
        if (bubble_raw && (events_q != {CNT_W{1'b1}})) begin
            events_d = events_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            cnt_q    <= 2'd0;
            fwd_rs_q <= 1'b0;
            fwd_rt_q <= 1'b0;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fwd_rs_q <= fwd_rs_d;
            fwd_rt_q <= fwd_rt_d;
            events_q <= events_d;
        end
    end

    // Reset masks the combinational controls so nothing stalls while the core is held.
    assign stall_if     = stall_raw & rst;
    assign bubble_ex    = bubble_raw & rst;
    assign stall_events = events_q;

endmodule

// File: tb/tb_load_use_stall.sv
// Drives three configurations of load_use_stall in lockstep (LOAD_LAT 1/3/2, one with a 2-bit counter)
// and compares them with a bubbles-owed reference model every cycle.
module tb_load_use_stall;

    localparam int N = 3;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        ex_valid;
    logic [15:0] ex_inst;
    logic        forward;
    logic        src;
    logic        flush;
    logic        mem_busy;

    logic [N-1:0] sif;
    logic [N-1:0] bub;
    logic [N-1:0] frs;
    logic [N-1:0] frt;
    logic [15:0]  ev [N];
    logic [15:0]  ev_a;
    logic [15:0]  ev_b;
    logic [1:0]   ev_sat;

    int checks;
    int failures;

    int pend [N];
    bit mfrs [N];
    bit mfrt [N];
    int mev  [N];

    assign ev[0] = ev_a;
    assign ev[1] = ev_b;
    assign ev[2] = {14'd0, ev_sat};

    load_use_stall #(.LOAD_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .ex_valid(ex_valid), .ex_inst(ex_inst),
        .forward(forward), .src(src), .flush(flush), .mem_busy(mem_busy),
        .stall_if(sif[0]), .bubble_ex(bub[0]), .fwd_rs_q(frs[0]), .fwd_rt_q(frt[0]),
        .stall_events(ev_a)
    );

    load_use_stall #(.LOAD_LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .ex_valid(ex_valid), .ex_inst(ex_inst),
        .forward(forward), .src(src), .flush(flush), .mem_busy(mem_busy),
        .stall_if(sif[1]), .bubble_ex(bub[1]), .fwd_rs_q(frs[1]), .fwd_rt_q(frt[1]),
        .stall_events(ev_b)
    );

    load_use_stall #(.LOAD_LAT(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .ex_valid(ex_valid), .ex_inst(ex_inst),
        .forward(forward), .src(src), .flush(flush), .mem_busy(mem_busy),
        .stall_if(sif[2]), .bubble_ex(bub[2]), .fwd_rs_q(frs[2]), .fwd_rt_q(frt[2]),
        .stall_events(ev_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int max_of(input int k);
        return (k == 2) ? 3 : 65535;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic iv, input logic xv, input logic [15:0] inst,
                          input logic fw, input logic s, input logic fl, input logic mb);
        id_valid = iv;
        ex_valid = xv;
        ex_inst  = inst;
        forward  = fw;
        src      = s;
        flush    = fl;
        mem_busy = mb;
    endtask

    // One clock: check every instance mid-cycle against the model, then advance the model.
    task automatic cycle();
        logic hz;
        logic esif;
        logic ebub;
        @(negedge clk);
        hz = id_valid & ex_valid & forward & (ex_inst[15:11] == 5'b10001);
        for (int k = 0; k < N; k++) begin
            if (flush) begin
                esif = 1'b0; ebub = 1'b0;
            end else if (mem_busy) begin
                esif = 1'b1; ebub = 1'b0;
            end else if (pend[k] > 0 || hz) begin
                esif = 1'b1; ebub = 1'b1;
            end else begin
                esif = 1'b0; ebub = 1'b0;
            end
            chk($sformatf("stall_if[%0d]", k), 32'(sif[k]), 32'(esif));
            chk($sformatf("bubble_ex[%0d]", k), 32'(bub[k]), 32'(ebub));
            chk($sformatf("fwd_rs_q[%0d]", k), 32'(frs[k]), 32'(mfrs[k]));
            chk($sformatf("fwd_rt_q[%0d]", k), 32'(frt[k]), 32'(mfrt[k]));
            chk($sformatf("stall_events[%0d]", k), 32'(ev[k]), 32'(mev[k]));
            if (flush) begin
                pend[k] = 0; mfrs[k] = 1'b0; mfrt[k] = 1'b0;
            end else if (!mem_busy) begin
                if (ebub) begin
                    pend[k] = (pend[k] > 0) ? pend[k] - 1 : lat_of(k) - 1;
                    if (mev[k] < max_of(k)) mev[k]++;
                    mfrs[k] = 1'b0; mfrt[k] = 1'b0;
                end else begin
                    mfrs[k] = id_valid & forward & ~src;
                    mfrt[k] = id_valid & forward & src;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_stall_if[%0d]", k), 32'(sif[k]), 32'd0);
            chk($sformatf("rst_bubble_ex[%0d]", k), 32'(bub[k]), 32'd0);
            chk($sformatf("rst_fwd_rs[%0d]", k), 32'(frs[k]), 32'd0);
            chk($sformatf("rst_fwd_rt[%0d]", k), 32'(frt[k]), 32'd0);
            chk($sformatf("rst_events[%0d]", k), 32'(ev[k]), 32'd0);
            pend[k] = 0; mfrs[k] = 1'b0; mfrt[k] = 1'b0; mev[k] = 0;
        end
        set_in(0, 0, 16'h0000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int ns;
        int nb;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        set_in(0, 0, 16'h0000, 0, 0, 0, 0);
        #1;

        // Reset and idle
        do_reset();
        repeat (10) cycle();

        // ALU producer: forward only, no stall
        set_in(1, 1, 16'hD8E0, 1, 1, 0, 0);
        #1;
        chk("alu_no_stall", 32'(sif[0]), 32'd0);
        cycle();
        set_in(0, 0, 16'h0000, 0, 0, 0, 0);
        chk("alu_fwd_rt", 32'(frt[0]), 32'd1);
        chk("alu_fwd_rs", 32'(frs[0]), 32'd0);
        cycle();

        // Load-use, single-cycle latency
        do_reset();
        set_in(1, 1, 16'h8820, 1, 0, 0, 0);
        #1;
        chk("ld1_stall", 32'(sif[0]), 32'd1);
        chk("ld1_bubble", 32'(bub[0]), 32'd1);
        cycle();
        set_in(0, 0, 16'h0000, 0, 0, 0, 0);
        #1;
        chk("ld1_released", 32'(sif[0]), 32'd0);
        chk("ld1_fwd_rs", 32'(frs[0]), 32'd0);
        chk("ld1_events", 32'(ev[0]), 32'd1);
        repeat (4) cycle();

        // Load-use, 3-cycle latency with mem_busy in the 2nd stall cycle for 2 cycles
        do_reset();
        ns = 0;
        nb = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) set_in(1, 1, 16'h8820, 1, 0, 0, 0);
            else        set_in(0, 0, 16'h0000, 0, 0, 0, (c == 1 || c == 2));
            #1;
            ns += int'(sif[1]);
            nb += int'(bub[1]);
            cycle();
        end
        chk("ld3_stall_cycles", 32'(ns), 32'd5);
        chk("ld3_bubble_cycles", 32'(nb), 32'd3);
        chk("ld3_events", 32'(ev[1]), 32'd3);

        // Flush in stall cycle 2
        do_reset();
        set_in(1, 1, 16'h8820, 1, 0, 0, 0);
        cycle();
        set_in(0, 0, 16'h0000, 0, 0, 1, 0);
        #1;
        chk("flush_stall", 32'(sif[1]), 32'd0);
        cycle();
        set_in(0, 0, 16'h0000, 0, 0, 0, 0);
        #1;
        chk("flush_run_next", 32'(sif[1]), 32'd0);
        chk("flush_events", 32'(ev[1]), 32'd1);
        cycle();

        // Reset asserted mid-stall
        set_in(1, 1, 16'h8820, 1, 1, 0, 0);
        cycle();
        set_in(0, 0, 16'h0000, 0, 0, 0, 0);
        cycle();
        set_in(1, 1, 16'h8820, 1, 1, 0, 0);
        do_reset();
        #1;
        chk("rst_midstall_run", 32'(sif[1]), 32'd0);
        cycle();

        // Saturation of the 2-bit counter
        do_reset();
        repeat (5) begin
            set_in(1, 1, 16'h8820, 1, 0, 0, 0);
            cycle();
            set_in(0, 0, 16'h0000, 0, 0, 0, 0);
            repeat (3) cycle();
        end
        chk("sat_events", 32'(ev[2]), 32'd3);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 1) == 1) ? 5'b10001 : 5'($urandom);
            set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                   {op, 11'($urandom)}, 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_use_stall.md
# load_use_stall

Load-use hazard controller and forward-control pipeline register in the decode stage, directly downstream of `forwarding_check`. It consumes `forward`/`src` for the decode (consumer) instruction against the execute (producer) instruction. If the producer is a load, it freezes fetch/decode and injects bubbles into execute for LOAD_LAT cycles. Otherwise it registers the rs/rt forward selects into the ID/EX boundary for the execute-stage operand muxes.

## Interface
- LOAD_LAT, 1: bubbles inserted per load-use hazard; legal 1..3.
- CNT_W, 16: width of the saturating stall-event counter.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- id_valid  input  1  decode holds a real instruction.
- ex_valid  input  1  execute holds a real (non-bubble) instruction.
- ex_inst  input  16  instruction in execute; load when ex_inst[15:11] = 5'b10001.
- forward  input  1  from `forwarding_check`: a decode source matches the execute destination.
- src  input  1  from `forwarding_check`: 0 = rs matched, 1 = rt matched.
- flush  input  1  branch/jump redirect; decode instruction is being squashed this cycle.
- mem_busy  input  1  data memory not ready; whole pipeline frozen.
- stall_if  output  1  hold PC and IF/ID register.
- bubble_ex  output  1  load NOP into ID/EX this cycle.
- fwd_rs_q  output  1  registered: execute rs operand takes the EX/MEM result.
- fwd_rt_q  output  1  registered: execute rt operand takes the EX/MEM result.
- stall_events  output  CNT_W  saturating count of hazard stall cycles.

## Operation
- hazard = id_valid & ex_valid & forward & (ex_inst[15:11] = 5'b10001).
- States: RUN, STALL. Down-counter cnt, 2 bits.
- Priority per cycle: rst > flush > mem_busy > hazard/STALL.
- RUN:
  - hazard & ~flush & ~mem_busy: stall_if = 1 and bubble_ex = 1 this cycle.
  - If LOAD_LAT > 1, go to STALL with cnt <= LOAD_LAT-2; else stay in RUN.
- STALL:
  - stall_if = 1 and bubble_ex = 1.
  - cnt = 0: go to RUN. Otherwise cnt <= cnt-1.
  - `forward`/`hazard` are ignored in STALL.
- flush = 1 (any state): stall_if = 0, bubble_ex = 0, next state RUN, cnt <= 0, fwd_*_q <= 0, stall_events unchanged.
- mem_busy = 1 and ~flush:
  - stall_if = 1, bubble_ex = 0.
  - state, cnt, fwd_*_q and stall_events hold.
  - A pending hazard is re-evaluated after mem_busy drops.
- Forward register update, every edge where ~flush & ~mem_busy:
  - If bubble_ex: fwd_rs_q <= 0, fwd_rt_q <= 0.
  - Else: fwd_rs_q <= id_valid & forward & ~src; fwd_rt_q <= id_valid & forward & src.
- stall_events:
  - Increments by 1 on each edge where bubble_ex = 1.
  - Saturates at all-ones; no wrap-around.
  - Cleared only by reset.

## Timing
- Reset (rst = 0, asynchronous):
  - state = RUN, cnt = 0, fwd_rs_q = 0, fwd_rt_q = 0, stall_events = 0.
  - stall_if and bubble_ex forced to 0 while rst is low.
- stall_if and bubble_ex are combinational from the inputs and state in the same cycle as detection, with zero latency.
- fwd_*_q take effect one cycle after the decode cycle that produced them, i.e. while that instruction is in execute.
- A load-use pair produces exactly LOAD_LAT consecutive stall_if/bubble_ex cycles, excluding mem_busy cycles. The consumer then leaves decode.
- After the stall, the load is in MEM/WB, so `forward` from the upstream block no longer fires against it. No re-trigger occurs because ex_valid = 0 for the bubble.
- Back-to-back load-use hazards: the second hazard is evaluated in the first RUN cycle after release.
- flush mid-STALL aborts the stall on that cycle; the next cycle is RUN.
- rst asserted mid-STALL returns all state to reset values immediately.

## Test plan
- Reset and idle: rst low, then high, with all inputs 0 -> all outputs 0; state RUN; stall_events = 0 for 10 cycles.
- ALU forward:
  - Stimulus: ex_inst = 0xD8E0 (ADD, opcode 11011), forward = 1, src = 1, id_valid = ex_valid = 1.
  - Expected: no stall; fwd_rt_q = 1 and fwd_rs_q = 0 on the next cycle.
- Load-use with LOAD_LAT = 1:
  - Stimulus: ex_inst = 0x8820 (LD, opcode 10001), forward = 1, src = 0.
  - Expected: stall_if = bubble_ex = 1 for exactly 1 cycle; fwd_*_q = 0 after; stall_events = 1.
- Load-use with LOAD_LAT = 3 and a disturbance:
  - Stimulus: same hazard, with mem_busy = 1 during the 2nd stall cycle for 2 cycles.
  - Expected: stall_if held for 5 cycles total; bubble_ex high for 3 of them; stall_events = 3.
- Flush during STALL (LOAD_LAT = 3):
  - Stimulus: assert flush in stall cycle 2.
  - Expected: stall_if = 0 that cycle; RUN next cycle; stall_events = 1.
- Saturation: CNT_W = 2, 5 separate load-use hazards -> stall_events reaches 3 and holds at 3.
